// File: rtl/apb_master.sv
`default_nettype none
// ============================================================================
// apb_master: single-outstanding command/response to APB requester bridge
//             with optional ACCESS-phase timeout. Rev 1.0
// ============================================================================
module apb_master #(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSELx,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] wait_cnt;
  logic        timeout_hit;

  // Abort on the ACCESS cycle that would be the TIMEOUT_CYCLES-th without PREADY.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && !PREADY && ((wait_cnt + 16'd1) == TIMEOUT_LIM);

  // Gated by PRESETn so the command port is closed while reset is held.
  assign cmd_ready = PRESETn && (state == IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (PREADY || timeout_hit) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      PADDR       <= '0;
      PSELx       <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PWDATA      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      PSELx   <= (state_nxt == SETUP) || (state_nxt == ACCESS);
      PENABLE <= (state_nxt == ACCESS);
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            PADDR    <= cmd_addr;
            PWRITE   <= cmd_write;
            PWDATA   <= cmd_write ? cmd_wdata : '0;
            wait_cnt <= '0;
          end
        end
        ACCESS: begin
          if (PREADY) begin
            rsp_valid   <= 1'b1;
            rsp_rdata   <= PWRITE ? '0 : PRDATA;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
            if (timeout_hit) begin
              rsp_valid   <= 1'b1;
              rsp_rdata   <= '0;
              rsp_err     <= 1'b1;
              rsp_timeout <= 1'b1;
            end
          end
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
